serv_csr_irq: RTL and testbench

- Parametrised successor CSR unit for the bit-serial core: W-bit datapath (1/2/4/8) and up to 16 platform local interrupts.
- Adds software interrupt, readable/writable MPIE, read-only mip, and a priority-encoded 5-bit mcause.
- Sits beside the register-file CSR path in the core. The state counter supplies the position of the current chunk. Read data flows out on o_q; write data is produced on o_csr_in.

---
 rtl/serv_csr_pkg.sv | 35 +++
 rtl/serv_irq_prio.sv | 36 +++
 rtl/serv_csr_irq.sv | 223 ++++++++++++++++++++++
 tb/tb_serv_csr_irq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_csr_pkg.sv
// Shared definitions for the bit-serial CSR/interrupt unit: CSR write sources,
// mcause codes and the bit positions of the interrupt-related CSR fields.
package serv_csr_pkg;

    typedef enum logic [1:0] {
        CSR_SOURCE_CSR = 2'd0,
        CSR_SOURCE_EXT = 2'd1,
        CSR_SOURCE_SET = 2'd2,
        CSR_SOURCE_CLR = 2'd3
    } csr_source_e;

    localparam logic [4:0] MCAUSE_MSI        = 5'd3;
    localparam logic [4:0] MCAUSE_MTI        = 5'd7;
    localparam logic [4:0] MCAUSE_MEI        = 5'd11;
    localparam logic [4:0] MCAUSE_LOCAL_BASE = 5'd16;
    localparam logic [4:0] MCAUSE_EBREAK     = 5'd3;
    localparam logic [4:0] MCAUSE_ECALL      = 5'd11;
    localparam logic [4:0] MCAUSE_LOAD       = 5'd4;
    localparam logic [4:0] MCAUSE_STORE      = 5'd6;
    localparam logic [4:0] MCAUSE_JUMP       = 5'd0;

    localparam int MSTATUS_MIE   = 3;
    localparam int MSTATUS_MPIE  = 7;
    localparam int IRQ_MSI_BIT   = 3;
    localparam int IRQ_MTI_BIT   = 7;
    localparam int IRQ_MEI_BIT   = 11;
    localparam int IRQ_LOCAL_BIT = 16;

    // mip and mie share one layout: MSI/MTI/MEI at 3/7/11, local lines from bit 16
    function automatic logic [31:0] irq_vec(input logic msi, input logic mti,
                                            input logic mei, input logic [15:0] lcl);
        return {lcl, 4'b0000, mei, 3'b000, mti, 3'b000, msi, 3'b000};
    endfunction

endpackage

// File: rtl/serv_irq_prio.sv
// Fixed-priority interrupt encoder: MEI, then MSI, then MTI, then local
// lines in ascending order. Inputs are expected to be already masked by mie.
module serv_irq_prio
    import serv_csr_pkg::*;
#(
    parameter int NIRQ = 4
) (
    input  logic            i_meip,
    input  logic            i_msip,
    input  logic            i_mtip,
    input  logic [NIRQ-1:0] i_lirq,
    output logic [4:0]      o_code,
    output logic            o_valid
);

    always_comb begin
        o_code = MCAUSE_JUMP;
        // Walk downwards so the lowest-numbered pending local line wins
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (i_lirq[k]) begin
                o_code = MCAUSE_LOCAL_BASE + 5'(k);
            end
        end
        if (i_mtip) begin
            o_code = MCAUSE_MTI;
        end
        if (i_msip) begin
            o_code = MCAUSE_MSI;
        end
        if (i_meip) begin
            o_code = MCAUSE_MEI;
        end
        o_valid = i_meip | i_msip | i_mtip | (|i_lirq);
    end

endmodule

// File: rtl/serv_csr_irq.sv
// Chunked CSR unit for the bit-serial core: mstatus MIE/MPIE, mie, live mip,
// mcause and the interrupt strobe logic, W bits per cycle at position i_cnt.
module serv_csr_irq
    import serv_csr_pkg::*;
#(
    parameter int    W              = 1,
    parameter int    NIRQ           = 4,
    parameter string RESET_STRATEGY = "MINI"
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic [4:0]      i_cnt,
    input  logic            i_cnt_done,
    input  logic            i_trig_irq,
    input  logic            i_trap,
    input  logic            i_mret,
    input  logic            i_e_op,
    input  logic            i_ebreak,
    input  logic            i_mem_op,
    input  logic            i_mem_cmd,
    input  logic            i_msip,
    input  logic            i_mtip,
    input  logic            i_meip,
    input  logic [NIRQ-1:0] i_lirq,
    output logic            o_new_irq,
    input  logic            i_mstatus_en,
    input  logic            i_mie_en,
    input  logic            i_mip_en,
    input  logic            i_mcause_en,
    input  logic [1:0]      i_csr_source,
    input  logic            i_csr_d_sel,
    input  logic [W-1:0]    i_rf_csr_out,
    input  logic [W-1:0]    i_csr_imm,
    input  logic [W-1:0]    i_rs1,
    output logic [W-1:0]    o_csr_in,
    output logic [W-1:0]    o_q
);

    localparam bit DO_RST = (RESET_STRATEGY != "NONE");

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            mie_msie_q, mie_msie_d;
    logic            mie_mtie_q, mie_mtie_d;
    logic            mie_meie_q, mie_meie_d;
    logic [NIRQ-1:0] mie_lie_q, mie_lie_d;
    logic            mcause_int_q, mcause_int_d;
    logic [4:0]      mcause_code_q, mcause_code_d;
    logic            irq_r_q, irq_r_d;
    logic            new_irq_q, new_irq_d;
    logic [4:0]      irq_code_q, irq_code_d;

    logic            trap_take;
    logic            rst_hit;
    logic            irq_now;
    logic            prio_valid;
    logic [4:0]      prio_code;
    logic [4:0]      exc_code;
    logic [31:0]     mip_vec;
    logic [31:0]     mie_vec;
    logic [31:0]     csr_rd_vec;
    logic [W-1:0]    rd_chunk;
    logic [W-1:0]    csr_d;

    function automatic logic wr_hit(input int b, input logic en, input logic [4:0] cnt);
        return en && (int'(cnt) == b - (b % W));
    endfunction

    function automatic logic wr_val(input int b, input logic [W-1:0] data);
        logic [W-1:0] sh;
        sh = data >> (b % W);
        return sh[0];
    endfunction

    assign trap_take = i_trap & i_cnt_done;
    assign rst_hit   = DO_RST && !i_rst_n;
    assign mip_vec   = irq_vec(i_msip, i_mtip, i_meip, 16'(i_lirq));
    assign mie_vec   = irq_vec(mie_msie_q, mie_mtie_q, mie_meie_q, 16'(mie_lie_q));

    serv_irq_prio #(
        .NIRQ (NIRQ)
    ) u_prio (
        .i_meip  (i_meip & mie_meie_q),
        .i_msip  (i_msip & mie_msie_q),
        .i_mtip  (i_mtip & mie_mtie_q),
        .i_lirq  (i_lirq & mie_lie_q),
        .o_code  (prio_code),
        .o_valid (prio_valid)
    );

    assign irq_now = prio_valid & mstatus_mie_q;

    always_comb begin
        csr_rd_vec = '0;
        if (i_mstatus_en) begin
            csr_rd_vec[MSTATUS_MIE]  = mstatus_mie_q;
            csr_rd_vec[MSTATUS_MPIE] = mstatus_mpie_q;
            csr_rd_vec[12:11]        = 2'b11;
        end
        if (i_mie_en) begin
            csr_rd_vec = csr_rd_vec | mie_vec;
        end
        if (i_mip_en) begin
            csr_rd_vec = csr_rd_vec | mip_vec;
        end
        if (i_mcause_en) begin
            csr_rd_vec[4:0] = csr_rd_vec[4:0] | mcause_code_q;
            csr_rd_vec[31]  = csr_rd_vec[31] | mcause_int_q;
        end
    end

    assign rd_chunk = csr_rd_vec[i_cnt +: W];
    assign o_q      = i_rf_csr_out | (i_en ? rd_chunk : '0);
    assign csr_d    = i_csr_d_sel ? i_csr_imm : i_rs1;

    always_comb begin
        case (csr_source_e'(i_csr_source))
            CSR_SOURCE_EXT: o_csr_in = csr_d;
            CSR_SOURCE_SET: o_csr_in = o_q | csr_d;
            CSR_SOURCE_CLR: o_csr_in = o_q & ~csr_d;
            default:        o_csr_in = o_q;
        endcase
    end

    always_comb begin
        if (i_e_op) begin
            exc_code = i_ebreak ? MCAUSE_EBREAK : MCAUSE_ECALL;
        end else if (i_mem_op) begin
            exc_code = i_mem_cmd ? MCAUSE_STORE : MCAUSE_LOAD;
        end else begin
            exc_code = MCAUSE_JUMP;
        end
    end

    // Later assignments win: CSR write, then mret, then trap entry
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_msie_d     = mie_msie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mie_lie_d      = mie_lie_q;
        mcause_int_d   = mcause_int_q;
        mcause_code_d  = mcause_code_q;
        irq_r_d        = irq_r_q;
        new_irq_d      = new_irq_q;
        irq_code_d     = irq_code_q;

        if (i_mstatus_en) begin
            if (wr_hit(MSTATUS_MIE, i_en, i_cnt))  mstatus_mie_d  = wr_val(MSTATUS_MIE, o_csr_in);
            if (wr_hit(MSTATUS_MPIE, i_en, i_cnt)) mstatus_mpie_d = wr_val(MSTATUS_MPIE, o_csr_in);
        end
        if (i_mie_en) begin
            if (wr_hit(IRQ_MSI_BIT, i_en, i_cnt)) mie_msie_d = wr_val(IRQ_MSI_BIT, o_csr_in);
            if (wr_hit(IRQ_MTI_BIT, i_en, i_cnt)) mie_mtie_d = wr_val(IRQ_MTI_BIT, o_csr_in);
            if (wr_hit(IRQ_MEI_BIT, i_en, i_cnt)) mie_meie_d = wr_val(IRQ_MEI_BIT, o_csr_in);
            for (int k = 0; k < NIRQ; k++) begin
                if (wr_hit(IRQ_LOCAL_BIT + k, i_en, i_cnt)) begin
                    mie_lie_d[k] = wr_val(IRQ_LOCAL_BIT + k, o_csr_in);
                end
            end
        end
        if (i_mcause_en) begin
            for (int b = 0; b < 5; b++) begin
                if (wr_hit(b, i_en, i_cnt)) mcause_code_d[b] = wr_val(b, o_csr_in);
            end
            if (wr_hit(31, i_en, i_cnt)) mcause_int_d = wr_val(31, o_csr_in);
        end

        if (i_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
        if (trap_take) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mcause_int_d   = new_irq_q;
            mcause_code_d  = new_irq_q ? irq_code_q : exc_code;
        end

        // The code is captured here and frozen until the next strobe
        if (i_trig_irq) begin
            irq_r_d    = irq_now;
            new_irq_d  = irq_now & ~irq_r_q;
            irq_code_d = prio_code;
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst_hit) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_msie_q     <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mie_lie_q      <= '0;
            irq_r_q        <= 1'b0;
            new_irq_q      <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_msie_q     <= mie_msie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mie_lie_q      <= mie_lie_d;
            irq_r_q        <= irq_r_d;
            new_irq_q      <= new_irq_d;
        end
    end

    // mcause and the latched code have no reset value; they only hold during reset
    always_ff @(posedge i_clk) begin
        if (!rst_hit) begin
            mcause_int_q  <= mcause_int_d;
            mcause_code_q <= mcause_code_d;
            irq_code_q    <= irq_code_d;
        end
    end

    assign o_new_irq = new_irq_q;

endmodule

// File: tb/tb_serv_csr_irq.sv
// Runs W=1, W=4 and W=8 instances through one directed sequence; expected
// values are queued as stimulus is issued and a negedge monitor checks them.
module tb_serv_csr_irq;

    localparam int NW          = 3;
    localparam int SEL_MSTATUS = 0;
    localparam int SEL_MIE     = 1;
    localparam int SEL_MIP     = 2;
    localparam int SEL_MCAUSE  = 3;
    localparam int SEL_NONE    = 4;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, trap, mret, cnt_done, trig;
    logic       e_op, ebreak, mem_op, mem_cmd;
    logic       msip, mtip, meip;
    logic [3:0] lirq;
    logic       mstatus_en, mie_en, mip_en, mcause_en;
    logic [1:0] csr_source;
    logic       d_sel;

    logic       en_a     [NW];
    logic [4:0] cnt_a    [NW];
    logic [7:0] rs1_a    [NW];
    logic [7:0] oq_a     [NW];
    logic [7:0] cin_a    [NW];
    logic       nirq_a   [NW];
    logic       samp_a   [NW];
    logic       last_a   [NW];
    logic [31:0] acc_a   [NW];
    logic       irq_samp;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic int wid(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
    endfunction

    for (genvar gi = 0; gi < NW; gi++) begin : g_dut
        localparam int WID = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);
        logic [WID-1:0] oq_w;
        logic [WID-1:0] cin_w;
        logic           nirq_w;

        serv_csr_irq #(
            .W              (WID),
            .NIRQ           (4),
            .RESET_STRATEGY ("MINI")
        ) dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_en         (en_a[gi]),
            .i_cnt        (cnt_a[gi]),
            .i_cnt_done   (cnt_done),
            .i_trig_irq   (trig),
            .i_trap       (trap),
            .i_mret       (mret),
            .i_e_op       (e_op),
            .i_ebreak     (ebreak),
            .i_mem_op     (mem_op),
            .i_mem_cmd    (mem_cmd),
            .i_msip       (msip),
            .i_mtip       (mtip),
            .i_meip       (meip),
            .i_lirq       (lirq),
            .o_new_irq    (nirq_w),
            .i_mstatus_en (mstatus_en),
            .i_mie_en     (mie_en),
            .i_mip_en     (mip_en),
            .i_mcause_en  (mcause_en),
            .i_csr_source (csr_source),
            .i_csr_d_sel  (d_sel),
            .i_rf_csr_out ({WID{1'b0}}),
            .i_csr_imm    (rs1_a[gi][WID-1:0]),
            .i_rs1        (rs1_a[gi][WID-1:0]),
            .o_csr_in     (cin_w),
            .o_q          (oq_w)
        );

        assign oq_a[gi]   = 8'(oq_w);
        assign cin_a[gi]  = 8'(cin_w);
        assign nirq_a[gi] = nirq_w;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: assembles read words chunk by chunk and pops expectations
    always @(negedge clk) begin
        logic [31:0] word;
        exp_t        e;
        for (int i = 0; i < NW; i++) begin
            if (samp_a[i]) begin
                word = acc_a[i] | (32'(oq_a[i]) << cnt_a[i]);
                if (last_a[i]) begin
                    acc_a[i] = '0;
                    if (sb_q.size() == 0) begin
                        check("scoreboard_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check(e.name, word, e.exp);
                    end
                end else begin
                    acc_a[i] = word;
                end
            end
            if (irq_samp) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, 32'(nirq_a[i]), e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int sel);
        mstatus_en = (sel == SEL_MSTATUS);
        mie_en     = (sel == SEL_MIE);
        mip_en     = (sel == SEL_MIP);
        mcause_en  = (sel == SEL_MCAUSE);
    endtask

    task automatic csr_op(input int wi, input int sel, input logic [1:0] src,
                          input logic [31:0] data, input bit rd);
        set_sel(sel);
        csr_source = src;
        for (int c = 0; c < 32; c += wid(wi)) begin
            en_a[wi]   = 1'b1;
            cnt_a[wi]  = 5'(c);
            rs1_a[wi]  = 8'(data >> c);
            samp_a[wi] = rd;
            last_a[wi] = rd && (c + wid(wi) == 32);
            tick();
        end
        en_a[wi]   = 1'b0;
        cnt_a[wi]  = '0;
        rs1_a[wi]  = '0;
        samp_a[wi] = 1'b0;
        last_a[wi] = 1'b0;
        csr_source = 2'd0;
        set_sel(SEL_NONE);
    endtask

    task automatic rd_all(input int sel, input string name, input logic [31:0] exp);
        for (int wi = 0; wi < NW; wi++) begin
            sb_q.push_back('{name: $sformatf("%s/W%0d", name, wid(wi)), exp: exp});
            csr_op(wi, sel, 2'd0, 32'd0, 1'b1);
            $display("read  %-16s W=%0d expect 0x%08h", name, wid(wi), exp);
        end
    endtask

    task automatic wr_all(input int sel, input logic [1:0] src, input logic [31:0] data);
        for (int wi = 0; wi < NW; wi++) begin
            csr_op(wi, sel, src, data, 1'b0);
            $display("write sel=%0d src=%0d W=%0d data 0x%08h", sel, src, wid(wi), data);
        end
    endtask

    task automatic irq_check(input string name, input logic exp);
        for (int wi = 0; wi < NW; wi++) begin
            sb_q.push_back('{name: $sformatf("%s/W%0d", name, wid(wi)), exp: 32'(exp)});
        end
        irq_samp = 1'b1;
        tick();
        irq_samp = 1'b0;
        $display("irq   %-16s expect new_irq=%0d", name, exp);
    endtask

    task automatic strobe();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic set_irq(input logic s, input logic t, input logic e, input logic [3:0] l);
        msip = s;
        mtip = t;
        meip = e;
        lirq = l;
    endtask

    task automatic do_trap(input logic eo, input logic eb, input logic mo, input logic mc,
                           input bit with_write);
        e_op     = eo;
        ebreak   = eb;
        mem_op   = mo;
        mem_cmd  = mc;
        trap     = 1'b1;
        cnt_done = 1'b1;
        if (with_write) begin
            for (int wi = 0; wi < NW; wi++) begin
                en_a[wi]  = 1'b1;
                cnt_a[wi] = '0;
                rs1_a[wi] = 8'hFF;
            end
            set_sel(SEL_MCAUSE);
            csr_source = 2'd1;
        end
        tick();
        for (int wi = 0; wi < NW; wi++) begin
            en_a[wi]  = 1'b0;
            rs1_a[wi] = '0;
        end
        set_sel(SEL_NONE);
        csr_source = 2'd0;
        trap = 1'b0;
        cnt_done = 1'b0;
        {e_op, ebreak, mem_op, mem_cmd} = 4'b0000;
    endtask

    task automatic do_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {trap, mret, cnt_done, trig} = 4'b0000;
        {e_op, ebreak, mem_op, mem_cmd} = 4'b0000;
        set_irq(1'b0, 1'b0, 1'b0, 4'b0000);
        set_sel(SEL_NONE);
        csr_source = 2'd0;
        d_sel      = 1'b0;
        irq_samp   = 1'b0;
        for (int i = 0; i < NW; i++) begin
            en_a[i]   = 1'b0;
            cnt_a[i]  = '0;
            rs1_a[i]  = '0;
            samp_a[i] = 1'b0;
            last_a[i] = 1'b0;
            acc_a[i]  = '0;
        end
        tick();
        rst_n = 1'b1;

        irq_check("rst_new_irq", 1'b0);
        rd_all(SEL_MSTATUS, "rst_mstatus", 32'h0000_1800);
        rd_all(SEL_MIE, "rst_mie", 32'h0000_0000);

        wr_all(SEL_MIE, 2'd2, 32'h0002_0080);
        wr_all(SEL_MSTATUS, 2'd2, 32'h0000_0008);
        rd_all(SEL_MIE, "mie_set", 32'h0002_0080);
        set_irq(1'b0, 1'b1, 1'b0, 4'b0010);
        rd_all(SEL_MIP, "mip_live", 32'h0002_0080);
        strobe();
        irq_check("irq_first", 1'b1);
        strobe();
        irq_check("irq_second", 1'b0);

        set_irq(1'b0, 1'b0, 1'b0, 4'b0000);
        strobe();
        set_irq(1'b0, 1'b1, 1'b0, 4'b0010);
        strobe();
        irq_check("irq_rearm", 1'b1);
        do_trap(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd_all(SEL_MCAUSE, "mcause_mti", 32'h8000_0007);
        rd_all(SEL_MSTATUS, "mstatus_trap", 32'h0000_1880);
        do_mret();
        rd_all(SEL_MSTATUS, "mstatus_mret", 32'h0000_1888);

        wr_all(SEL_MIE, 2'd3, 32'h0000_0080);
        rd_all(SEL_MIE, "mie_clr", 32'h0002_0000);
        set_irq(1'b0, 1'b0, 1'b0, 4'b0000);
        strobe();
        set_irq(1'b0, 1'b1, 1'b0, 4'b0010);
        strobe();
        irq_check("irq_local", 1'b1);
        do_trap(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd_all(SEL_MCAUSE, "mcause_local1", 32'h8000_0011);
        do_mret();

        wr_all(SEL_MIE, 2'd2, 32'h0000_0808);
        rd_all(SEL_MIE, "mie_all", 32'h0002_0808);
        set_irq(1'b0, 1'b0, 1'b0, 4'b0000);
        strobe();
        set_irq(1'b1, 1'b1, 1'b1, 4'b0010);
        rd_all(SEL_MIP, "mip_all", 32'h0002_0888);
        strobe();
        irq_check("irq_mei", 1'b1);
        do_trap(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd_all(SEL_MCAUSE, "mcause_mei", 32'h8000_000B);
        do_mret();

        set_irq(1'b0, 1'b0, 1'b0, 4'b0000);
        strobe();
        irq_check("irq_clear", 1'b0);
        do_trap(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rd_all(SEL_MCAUSE, "mcause_ecall", 32'h0000_000B);
        do_trap(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rd_all(SEL_MCAUSE, "mcause_ebreak", 32'h0000_0003);
        do_trap(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rd_all(SEL_MCAUSE, "mcause_load", 32'h0000_0004);
        do_trap(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        rd_all(SEL_MCAUSE, "mcause_store", 32'h0000_0006);
        do_trap(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd_all(SEL_MCAUSE, "mcause_jump", 32'h0000_0000);
        do_trap(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        rd_all(SEL_MCAUSE, "trap_over_write", 32'h0000_0006);

        set_irq(1'b1, 1'b0, 1'b0, 4'b0100);
        wr_all(SEL_MIP, 2'd1, 32'hFFFF_FFFF);
        rd_all(SEL_MIP, "mip_ro", 32'h0004_0008);

        wr_all(SEL_MSTATUS, 2'd2, 32'h0000_0088);
        rd_all(SEL_MSTATUS, "mstatus_set", 32'h0000_1888);
        strobe();
        irq_check("irq_pre_rst", 1'b1);
        rst_n    = 1'b0;
        trap     = 1'b1;
        cnt_done = 1'b1;
        tick();
        rst_n    = 1'b1;
        trap     = 1'b0;
        cnt_done = 1'b0;
        irq_check("rst_over_trap", 1'b0);
        rd_all(SEL_MSTATUS, "rst_mstatus2", 32'h0000_1800);
        rd_all(SEL_MIE, "rst_mie2", 32'h0000_0000);

        tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
